// File: rtl/jar_seq_pkg.sv
// Shared types and default sizes for the digit sequencer.
// Imported by jar_digit_sequencer and jar_seq_prescaler.
package jar_seq_pkg;

  localparam int IDX_W_DEF  = 10;
  localparam int DIGITS_DEF = 1024;
  localparam int RATE_W_DEF = 4;
  localparam int BEAT_W     = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LOAD = 2'd2
  } seq_state_e;

endpackage

// File: rtl/jar_seq_prescaler.sv
// Rate divider: ticks once every rate+1 enabled clocks; clear or reset zeroes the count.
// The >= compare keeps a lowered rate from overrunning a count already past it.
module jar_seq_prescaler
  import jar_seq_pkg::*;
#(
  parameter int RATE_W = RATE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              en,
  input  logic [RATE_W-1:0] rate,
  output logic              tick
);

  logic [RATE_W-1:0] count;

  assign tick = en && (count >= rate);

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (en) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/jar_digit_sequencer.sv
// Digit index sequencer: two-beat index load, rate-gated stepping, step/wrap strobes.
// Optional JAR_SEQ_ONESHOT_EN: stop in IDLE after one full pass until stream toggles low.
module jar_digit_sequencer
  import jar_seq_pkg::*;
#(
  parameter int IDX_W  = IDX_W_DEF,
  parameter int DIGITS = DIGITS_DEF,
  parameter int RATE_W = RATE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stream,
  input  logic              load,
  input  logic [BEAT_W-1:0] load_data,
  input  logic [RATE_W-1:0] rate,
  output logic [IDX_W-1:0]  index,
  output logic              step,
  output logic              wrap,
  output logic [1:0]        state
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  seq_state_e          cur_q, nxt;
  logic [BEAT_W-1:0]   lo_q, lo_nxt;
  logic [IDX_W-1:0]    index_nxt;
  logic                step_nxt, wrap_nxt;
  logic [2*BEAT_W-1:0] beat_val;
  logic                run_en, tick, can_start;

  assign run_en   = (cur_q == ST_RUN) && !load && stream;
  assign beat_val = {load_data, lo_q};
  assign state    = cur_q;

  jar_seq_prescaler #(.RATE_W(RATE_W)) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clear (!run_en),
    .en    (run_en),
    .rate  (rate),
    .tick  (tick)
  );

`ifdef JAR_SEQ_ONESHOT_EN
  logic armed_q;

  // A pass that ended in a wrap needs stream seen low before a new pass may start.
  always_ff @(posedge clk) begin
    if (reset || !stream) begin
      armed_q <= 1'b1;
    end else if (wrap_nxt) begin
      armed_q <= 1'b0;
    end
  end

  assign can_start = stream && armed_q;
`else
  assign can_start = stream;
`endif

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    nxt       = cur_q;
    lo_nxt    = lo_q;
    index_nxt = index;
    step_nxt  = 1'b0;
    wrap_nxt  = 1'b0;
    case (cur_q)
      ST_IDLE: begin
        if (load) begin
          lo_nxt = load_data;
          nxt    = ST_LOAD;
        end else if (can_start) begin
          nxt = ST_RUN;
        end
      end
      ST_LOAD: begin
        if (load) begin
          index_nxt = (int'(beat_val) >= DIGITS) ? '0 : IDX_W'(beat_val);
          step_nxt  = 1'b1;
          nxt       = can_start ? ST_RUN : ST_IDLE;
        end
      end
      ST_RUN: begin
        if (load) begin
          lo_nxt = load_data;
          nxt    = ST_LOAD;
        end else if (!stream) begin
          nxt = ST_IDLE;
        end else if (tick) begin
          step_nxt = 1'b1;
          if (index == LAST_IDX) begin
            index_nxt = '0;
            wrap_nxt  = 1'b1;
`ifdef JAR_SEQ_ONESHOT_EN
            nxt       = ST_IDLE;
`endif
          end else begin
            index_nxt = index + IDX_W'(1);
          end
        end
      end
      default: nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cur_q <= ST_IDLE;
      lo_q  <= '0;
      index <= '0;
      step  <= 1'b0;
      wrap  <= 1'b0;
    end else begin
      cur_q <= nxt;
      lo_q  <= lo_nxt;
      index <= index_nxt;
      step  <= step_nxt;
      wrap  <= wrap_nxt;
    end
  end

endmodule
